csr_init_sequencer: RTL and testbench

CSR_INIT_SEQUENCER -- requirements
Module: csr_init_sequencer

---
 rtl/csr_init_sequencer_pkg.sv | 42 ++++
 rtl/csr_init_sequencer_if.sv | 45 ++++
 rtl/csr_init_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_csr_init_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_init_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_init_sequencer_pkg
//  Description : Shared types and constants for the CSR init sequencer.
//                It holds the sequencer state encoding, the two reserved
//                table addresses (end marker and delay entry), and the field
//                layout of a 48-bit table entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package csr_init_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_WRITE  = 3'd3,
        ST_GAP    = 3'd4,
        ST_DELAY  = 3'd5,
        ST_DONE   = 3'd6
    } seqState_t;

    // Reserved table addresses
    localparam logic [15:0] cEndMarker   = 16'hFFFE;
    localparam logic [15:0] cDelayMarker = 16'hFFFF;

    // Table entry layout: [47:32] CSR address, [31:0] CSR data
    localparam int cEntryBit = 48;
    localparam int cAdrsMsb  = 47;
    localparam int cAdrsLsb  = 32;
    localparam int cDataMsb  = 31;
    localparam int cDataLsb  = 0;

    function automatic logic [15:0] entryAdrs(input logic [cEntryBit-1:0] entry);
        return entry[cAdrsMsb:cAdrsLsb];
    endfunction

    function automatic logic [31:0] entryData(input logic [cEntryBit-1:0] entry);
        return entry[cDataMsb:cDataLsb];
    endfunction

endpackage : csr_init_sequencer_pkg
`default_nettype wire

// File: rtl/csr_init_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : csr_init_sequencer_if
//  Description : Bus bundle between the CSR init sequencer and its
//                surroundings: the table read port (index out, entry back one
//                cycle later) and the USI CSR write port toward the I2C block.
//                  oTblAdrs   table read index
//                  iTblData   48-bit table entry, valid one cycle after index
//                  oSUsiWd    CSR write data
//                  oSUsiAdrs  CSR address
//                  oSUsiWCke  one-cycle CSR write strobe
//                master: the sequencer side; slave: table ROM / CSR target side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface csr_init_sequencer_if
    import csr_init_sequencer_pkg::*;
#(
    parameter int pTblAdrsBit = 5,
    parameter int pBusAdrsBit = 15
) ();

    logic [pTblAdrsBit-1:0] oTblAdrs;
    logic [cEntryBit-1:0]   iTblData;
    logic [31:0]            oSUsiWd;
    logic [pBusAdrsBit:0]   oSUsiAdrs;
    logic                   oSUsiWCke;

    modport master (
        output oTblAdrs,
        input  iTblData,
        output oSUsiWd,
        output oSUsiAdrs,
        output oSUsiWCke
    );

    modport slave (
        input  oTblAdrs,
        output iTblData,
        input  oSUsiWd,
        input  oSUsiAdrs,
        input  oSUsiWCke
    );

endinterface : csr_init_sequencer_if
`default_nettype wire

// File: rtl/csr_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : csr_init_sequencer
//  Description : Walks a table of {address, data} entries and issues one USI
//                CSR write per entry, with an idle gap after every write.
//                Address 16'hFFFE ends the run, 16'hFFFF inserts a wait of
//                <data> cycles. Running off the last table index without an
//                end marker raises the sticky oErr and ends the run.
//                The table itself (a 1-cycle-latency ROM) lives alongside
//                this block at the I2C block level and is reached through
//                the bus interface.
//  Ports       : iSysClk   clock, rising edge
//                iSysRst   asynchronous reset, active low
//                iStart    one-cycle request to run the table from entry 0
//                iAbort    stop the sequence on the next edge
//                bus       table read port + USI CSR write port (master)
//                oBusy     sequence in progress
//                oDone     one-cycle pulse on normal completion / overrun
//                oErr      sticky overrun flag, cleared by an accepted iStart
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_init_sequencer
    import csr_init_sequencer_pkg::*;
#(
    parameter int pTblAdrsBit = 5,
    parameter int pGapCycle   = 4,
    parameter int pBusAdrsBit = 15      // must not exceed 15 (16-bit entry address)
) (
    input  logic                 iSysClk,
    input  logic                 iSysRst,
    input  logic                 iStart,
    input  logic                 iAbort,
    csr_init_sequencer_if.master bus,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oErr
);

    localparam logic [pTblAdrsBit-1:0] cTblLast = '1;
    localparam logic [pTblAdrsBit-1:0] cTblOne  = {{(pTblAdrsBit-1){1'b0}}, 1'b1};
    localparam bit                     cNoGap   = (pGapCycle == 0);
    // Counter runs down to zero, so a gap of N cycles loads N-1
    localparam logic [31:0]            cGapLoad = (pGapCycle > 0) ? 32'(pGapCycle - 1) : 32'd0;

    seqState_t              rState;
    seqState_t              wNextState;

    logic [pTblAdrsBit-1:0] rTblAdrs;
    logic [31:0]            rCnt;
    logic [pBusAdrsBit:0]   rUsiAdrs;
    logic [31:0]            rUsiWd;
    logic                   rErr;

    logic [15:0]            wEntryAdrs;
    logic [31:0]            wEntryData;
    logic [31:0]            wDelayLoad;
    logic                   wLastEntry;

    logic                   wAccept;     // iStart taken in IDLE
    logic                   wLatchWrite; // capture CSR address/data in DECODE
    logic                   wLoadGap;
    logic                   wLoadDelay;
    logic                   wStepEntry;  // current entry finished, move on

    assign wEntryAdrs = entryAdrs(bus.iTblData);
    assign wEntryData = entryData(bus.iTblData);
    // A zero-length delay still spends one cycle in DELAY
    assign wDelayLoad = (wEntryData == 32'd0) ? 32'd0 : (wEntryData - 32'd1);
    assign wLastEntry = (rTblAdrs == cTblLast);

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        wNextState  = rState;
        wAccept     = 1'b0;
        wLatchWrite = 1'b0;
        wLoadGap    = 1'b0;
        wLoadDelay  = 1'b0;
        wStepEntry  = 1'b0;

        if (iAbort) begin
            wNextState = ST_IDLE;
        end else begin
            case (rState)
                ST_IDLE: begin
                    if (iStart) begin
                        wAccept    = 1'b1;
                        wNextState = ST_FETCH;
                    end
                end
                // Table read is in flight; entry is visible in DECODE
                ST_FETCH:  wNextState = ST_DECODE;
                ST_DECODE: begin
                    if (wEntryAdrs == cEndMarker) begin
                        wNextState = ST_DONE;
                    end else if (wEntryAdrs == cDelayMarker) begin
                        wLoadDelay = 1'b1;
                        wNextState = ST_DELAY;
                    end else begin
                        wLatchWrite = 1'b1;
                        wNextState  = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (cNoGap) begin
                        wStepEntry = 1'b1;
                    end else begin
                        wLoadGap   = 1'b1;
                        wNextState = ST_GAP;
                    end
                end
                ST_GAP:   wStepEntry = (rCnt == 32'd0);
                ST_DELAY: wStepEntry = (rCnt == 32'd0);
                ST_DONE:  wNextState = ST_IDLE;
                default:  wNextState = ST_IDLE;
            endcase

            // Leaving an entry: either fetch the next one or, past the last
            // index, stop with an overrun instead of wrapping to 0.
            if (wStepEntry) begin
                wNextState = wLastEntry ? ST_DONE : ST_FETCH;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge iSysClk or negedge iSysRst) begin
        if (!iSysRst) begin
            rState <= ST_IDLE;
        end else begin
            rState <= wNextState;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: table index, shared gap/delay counter, CSR holding regs
    // ------------------------------------------------------------------
    always_ff @(posedge iSysClk or negedge iSysRst) begin
        if (!iSysRst) begin
            rTblAdrs <= '0;
            rCnt     <= 32'd0;
            rUsiAdrs <= '0;
            rUsiWd   <= 32'd0;
            rErr     <= 1'b0;
        end else begin
            if (wAccept) begin
                rTblAdrs <= '0;
                rErr     <= 1'b0;
            end else if (wStepEntry && !wLastEntry) begin
                rTblAdrs <= rTblAdrs + cTblOne;
            end

            if (wStepEntry && wLastEntry) begin
                rErr <= 1'b1;
            end

            if (wLatchWrite) begin
                rUsiAdrs <= wEntryAdrs[pBusAdrsBit:0];
                rUsiWd   <= wEntryData;
            end

            if (wLoadGap) begin
                rCnt <= cGapLoad;
            end else if (wLoadDelay) begin
                rCnt <= wDelayLoad;
            end else if (((rState == ST_GAP) || (rState == ST_DELAY)) && (rCnt != 32'd0)) begin
                rCnt <= rCnt - 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.oTblAdrs  = rTblAdrs;
    assign bus.oSUsiAdrs = rUsiAdrs;
    assign bus.oSUsiWd   = rUsiWd;
    assign bus.oSUsiWCke = (rState == ST_WRITE);
    assign oBusy         = (rState != ST_IDLE);
    assign oDone         = (rState == ST_DONE);
    assign oErr          = rErr;

endmodule : csr_init_sequencer
`default_nettype wire

// File: tb/tb_csr_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_init_sequencer
//  Description : Self-checking bench for csr_init_sequencer. A behavioural
//                1-cycle-latency table ROM feeds the DUT; expected CSR writes
//                are derived from the table contents, queued when a run is
//                started and popped as strobes appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_init_sequencer;
    import csr_init_sequencer_pkg::*;

    localparam int pTblAdrsBit = 5;
    localparam int pGapCycle   = 4;
    localparam int pBusAdrsBit = 15;
    localparam int cEntries    = 1 << pTblAdrsBit;

    logic iSysClk = 1'b0;
    logic iSysRst = 1'b1;
    logic iStart  = 1'b0;
    logic iAbort  = 1'b0;
    logic oBusy;
    logic oDone;
    logic oErr;

    csr_init_sequencer_if #(.pTblAdrsBit(pTblAdrsBit), .pBusAdrsBit(pBusAdrsBit)) bus ();

    csr_init_sequencer #(
        .pTblAdrsBit(pTblAdrsBit),
        .pGapCycle  (pGapCycle),
        .pBusAdrsBit(pBusAdrsBit)
    ) dut (
        .iSysClk(iSysClk),
        .iSysRst(iSysRst),
        .iStart (iStart),
        .iAbort (iAbort),
        .bus    (bus),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oErr   (oErr)
    );

    always #5 iSysClk = ~iSysClk;

    // Table ROM model: registered read, one cycle of latency
    logic [47:0] tbl [cEntries];
    always @(posedge iSysClk) bus.iTblData <= tbl[bus.oTblAdrs];

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [47:0] ent [4];
        logic        expErr;
        int          expWrites;
    } vec_t;

    wr_t  expQ [$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   strobeCnt = 0;
    int   doneCnt   = 0;
    int   lastDoneCyc = 0;
    int   strobeCyc [$];
    logic wrapSeen  = 1'b0;
    logic [pTblAdrsBit-1:0] prevAdrs = '0;
    int   holdCnt   = 0;
    logic [15:0] holdA = '0;
    logic [31:0] holdD = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] mk(input logic [15:0] a, input logic [31:0] d);
        return {a, d};
    endfunction

    always @(posedge iSysClk) cyc++;

    // Output monitor / scoreboard
    always @(negedge iSysClk) begin
        if (!iSysRst) begin
            holdCnt  = 0;
            prevAdrs = '0;
        end else begin
            if (bus.oSUsiWCke) begin
                strobeCnt++;
                strobeCyc.push_back(cyc);
                chk("strobe_expected", 64'(expQ.size() > 0), 64'd1);
                if (expQ.size() > 0) begin
                    wr_t e;
                    e = expQ.pop_front();
                    chk("strobe_adrs", 64'(bus.oSUsiAdrs), 64'(e.a));
                    chk("strobe_wd",   64'(bus.oSUsiWd),   64'(e.d));
                end
                holdCnt = pGapCycle;
                holdA   = bus.oSUsiAdrs;
                holdD   = bus.oSUsiWd;
            end else if (holdCnt > 0) begin
                if (oBusy) begin
                    chk("gap_hold_adrs", 64'(bus.oSUsiAdrs), 64'(holdA));
                    chk("gap_hold_wd",   64'(bus.oSUsiWd),   64'(holdD));
                end
                holdCnt--;
            end
            if (oDone) begin
                doneCnt++;
                lastDoneCyc = cyc;
            end
            if (oBusy) begin
                if (bus.oTblAdrs < prevAdrs) wrapSeen = 1'b1;
                prevAdrs = bus.oTblAdrs;
            end else begin
                prevAdrs = '0;
            end
        end
    end

    task automatic fillEnd();
        for (int i = 0; i < cEntries; i++) tbl[i] = mk(cEndMarker, 32'd0);
    endtask

    // Reference walk of the table: every non-reserved entry up to the first
    // end marker (or the last index) becomes one expected write.
    task automatic modelRun();
        for (int i = 0; i < cEntries; i++) begin
            logic [47:0] e;
            e = tbl[i];
            if (e[47:32] == cEndMarker) break;
            if (e[47:32] != cDelayMarker) expQ.push_back('{a: e[47:32], d: e[31:0]});
        end
    endtask

    task automatic pulseStart();
        @(posedge iSysClk); #1 iStart = 1'b1;
        @(posedge iSysClk); #1 iStart = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while (oBusy && n < budget) begin
            @(negedge iSysClk);
            n++;
        end
        if (n >= budget) chk({name, "_idle_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic waitStrobe(input string name, input int budget);
        int n = 0;
        while (!bus.oSUsiWCke && n < budget) begin
            @(negedge iSysClk);
            n++;
        end
        if (n >= budget) chk({name, "_strobe_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic runSeq(input string name, input int budget, input logic expErr);
        int d0 = doneCnt;
        modelRun();
        pulseStart();
        waitIdle(name, budget);
        chk({name, "_done_pulse"}, 64'(doneCnt - d0), 64'd1);
        chk({name, "_err"},        64'(oErr),         64'(expErr));
        chk({name, "_drained"},    64'(expQ.size()),  64'd0);
    endtask

    vec_t vecs [5];

    initial begin
        int s0;
        int c0;
        int d0;

        vecs[0].ent = '{mk(16'h0404, 32'd250), mk(16'h0400, 32'd1), mk(cEndMarker, 32'd0), mk(cEndMarker, 32'd0)};
        vecs[0].expErr = 1'b0; vecs[0].expWrites = 2;
        vecs[1].ent = '{mk(cEndMarker, 32'd0), mk(16'h1111, 32'd1), mk(cEndMarker, 32'd0), mk(cEndMarker, 32'd0)};
        vecs[1].expErr = 1'b0; vecs[1].expWrites = 0;
        vecs[2].ent = '{mk(16'h1234, 32'hDEADBEEF), mk(cDelayMarker, 32'd3), mk(16'h0010, 32'd0), mk(cEndMarker, 32'd0)};
        vecs[2].expErr = 1'b0; vecs[2].expWrites = 2;
        vecs[3].ent = '{mk(cDelayMarker, 32'd0), mk(16'h00AA, 32'd5), mk(cEndMarker, 32'd0), mk(cEndMarker, 32'd0)};
        vecs[3].expErr = 1'b0; vecs[3].expWrites = 1;
        vecs[4].ent = '{mk(16'h0000, 32'hFFFFFFFF), mk(16'h7FFF, 32'h12345678), mk(16'hFFFD, 32'd1), mk(cEndMarker, 32'd0)};
        vecs[4].expErr = 1'b0; vecs[4].expWrites = 3;

        fillEnd();

        // Reset state
        #2 iSysRst = 1'b0;
        repeat (3) @(posedge iSysClk);
        #1;
        chk("rst_tbladrs", 64'(bus.oTblAdrs),  64'd0);
        chk("rst_wd",      64'(bus.oSUsiWd),   64'd0);
        chk("rst_adrs",    64'(bus.oSUsiAdrs), 64'd0);
        chk("rst_wcke",    64'(bus.oSUsiWCke), 64'd0);
        chk("rst_busy",    64'(oBusy),         64'd0);
        chk("rst_done",    64'(oDone),         64'd0);
        chk("rst_err",     64'(oErr),          64'd0);
        iSysRst = 1'b1;
        repeat (2) @(posedge iSysClk);

        // Table-driven runs
        for (int v = 0; v < 5; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            fillEnd();
            for (int k = 0; k < 4; k++) tbl[k] = vecs[v].ent[k];
            s0 = strobeCnt;
            runSeq(nm, 2000, vecs[v].expErr);
            chk({nm, "_writes"}, 64'(strobeCnt - s0), 64'(vecs[v].expWrites));
            if (v == 0 && strobeCnt - s0 == 2) begin
                int dd;
                chk("vec0_spacing", 64'(strobeCyc[s0+1] - strobeCyc[s0]), 64'(3 + pGapCycle));
                dd = lastDoneCyc - strobeCyc[s0+1];
                chk("vec0_done_after_strobe", 64'(dd >= 4 && dd <= 8), 64'd1);
            end
        end

        // Long delay entry ahead of the only write
        fillEnd();
        tbl[0] = mk(cDelayMarker, 32'd100);
        tbl[1] = mk(16'h0400, 32'd1);
        s0 = strobeCnt;
        c0 = cyc;
        runSeq("delay", 2000, 1'b0);
        chk("delay_writes", 64'(strobeCnt - s0), 64'd1);
        if (strobeCnt - s0 >= 1)
            chk("delay_min_wait", 64'(strobeCyc[s0] - c0 >= 100), 64'd1);

        // Full table with no end marker: overrun
        for (int i = 0; i < cEntries; i++) tbl[i] = mk(16'(16'h0100 + i), 32'(i * 3));
        wrapSeen = 1'b0;
        s0 = strobeCnt;
        runSeq("overrun", 2000, 1'b1);
        chk("overrun_writes", 64'(strobeCnt - s0), 64'(cEntries));
        chk("overrun_nowrap", 64'(wrapSeen),       64'd0);

        // Next accepted start clears the sticky error
        fillEnd();
        runSeq("errclr", 200, 1'b0);

        // Abort in the gap after the first write
        fillEnd();
        tbl[0] = mk(16'h0404, 32'd250);
        tbl[1] = mk(16'h0400, 32'd1);
        s0 = strobeCnt;
        d0 = doneCnt;
        modelRun();
        pulseStart();
        waitStrobe("abort", 100);
        @(posedge iSysClk); #1 iAbort = 1'b1;
        @(posedge iSysClk); #1 iAbort = 1'b0;
        chk("abort_busy", 64'(oBusy), 64'd0);
        expQ.delete();
        repeat (40) @(negedge iSysClk);
        chk("abort_writes", 64'(strobeCnt - s0), 64'd1);
        chk("abort_nodone", 64'(doneCnt - d0),   64'd0);
        chk("abort_err",    64'(oErr),           64'd0);

        s0 = strobeCnt;
        runSeq("rerun", 200, 1'b0);
        chk("rerun_writes", 64'(strobeCnt - s0), 64'd2);

        // Abort wins over start in the same cycle
        s0 = strobeCnt;
        @(posedge iSysClk); #1 begin iStart = 1'b1; iAbort = 1'b1; end
        @(posedge iSysClk); #1 begin iStart = 1'b0; iAbort = 1'b0; end
        chk("abort_prio_busy", 64'(oBusy), 64'd0);
        repeat (20) @(negedge iSysClk);
        chk("abort_prio_writes", 64'(strobeCnt - s0), 64'd0);

        // Start while busy is ignored
        s0 = strobeCnt;
        d0 = doneCnt;
        modelRun();
        pulseStart();
        waitStrobe("busystart", 100);
        @(posedge iSysClk); #1 iStart = 1'b1;
        @(posedge iSysClk); #1 iStart = 1'b0;
        waitIdle("busystart", 200);
        chk("busystart_writes", 64'(strobeCnt - s0), 64'd2);
        chk("busystart_done",   64'(doneCnt - d0),   64'd1);
        repeat (20) @(negedge iSysClk);
        chk("busystart_norerun", 64'(strobeCnt - s0), 64'd2);

        // Reset dropped mid-sequence, off the clock edge
        modelRun();
        pulseStart();
        waitStrobe("midrst", 100);
        @(posedge iSysClk); #3 iSysRst = 1'b0;
        #1;
        chk("midrst_tbladrs", 64'(bus.oTblAdrs),  64'd0);
        chk("midrst_wd",      64'(bus.oSUsiWd),   64'd0);
        chk("midrst_adrs",    64'(bus.oSUsiAdrs), 64'd0);
        chk("midrst_wcke",    64'(bus.oSUsiWCke), 64'd0);
        chk("midrst_busy",    64'(oBusy),         64'd0);
        chk("midrst_done",    64'(oDone),         64'd0);
        chk("midrst_err",     64'(oErr),          64'd0);
        expQ.delete();
        repeat (3) @(posedge iSysClk);
        #1 iSysRst = 1'b1;
        s0 = strobeCnt;
        repeat (40) @(negedge iSysClk);
        chk("midrst_nostrobe", 64'(strobeCnt - s0), 64'd0);
        chk("midrst_idle",     64'(oBusy),          64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_csr_init_sequencer
`default_nettype wire
